// File: rtl/cam_capture.sv
// ---------------------------------------------------------------------------
// cam_capture
//
// Camera front-end: samples an OV7670-style parallel bus (PCLK/HREF/VSYNC,
// RGB565 two bytes per pixel) in the system clock domain, assembles byte
// pairs into pixels, expands them to RGB888 and emits one-cycle pixel
// strobes. Tracks frame geometry and raises a sticky error on malformed
// lines or frames.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   cam_pclk_i     camera pixel clock, sampled as data
//   cam_vsync_i    high during vertical blanking
//   cam_href_i     high while line bytes are valid
//   cam_data_i     camera byte
//   cam_red_o      expanded red   (holds between strobes)
//   cam_green_o    expanded green (holds between strobes)
//   cam_blue_o     expanded blue  (holds between strobes)
//   cam_done_o     one-cycle pixel-valid strobe
//   frame_start_o  one-cycle pulse when a frame starts (vsync fall)
//   frame_done_o   one-cycle pulse when a frame ends (vsync rise)
//   cap_err_o      sticky geometry error, cleared only by rst
// ---------------------------------------------------------------------------
module cam_capture #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk_i,
    input  logic       cam_vsync_i,
    input  logic       cam_href_i,
    input  logic [7:0] cam_data_i,
    output logic [7:0] cam_red_o,
    output logic [7:0] cam_green_o,
    output logic [7:0] cam_blue_o,
    output logic       cam_done_o,
    output logic       frame_start_o,
    output logic       frame_done_o,
    output logic       cap_err_o
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Synchroniser bundle layout: {pclk, vsync, href, data[7:0]}
    logic [10:0] s1_q, s1_d;
    logic [10:0] s2_q, s2_d;
    // Registered copies of the synced control lines for edge detection
    logic        pclk_s3_q, pclk_s3_d;
    logic        vsync_s3_q, vsync_s3_d;
    logic        href_s3_q, href_s3_d;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       red_q, red_d;
    logic [7:0]       green_q, green_d;
    logic [7:0]       blue_q, blue_d;
    logic             done_q, done_d;
    logic             fstart_q, fstart_d;
    logic             fdone_q, fdone_d;
    logic             err_q, err_d;

    logic       pclk_s2;
    logic       vsync_s2;
    logic       href_s2;
    logic [7:0] data_s2;
    logic       pe;
    logic       vs_fall;
    logic       vs_rise;
    logic       href_fall;

    assign pclk_s2  = s2_q[10];
    assign vsync_s2 = s2_q[9];
    assign href_s2  = s2_q[8];
    assign data_s2  = s2_q[7:0];

    assign pe        = pclk_s2 & ~pclk_s3_q;
    assign vs_fall   = ~vsync_s2 & vsync_s3_q;
    assign vs_rise   = vsync_s2 & ~vsync_s3_q;
    assign href_fall = ~href_s2 & href_s3_q;

    always_comb begin
        s1_d       = {cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i};
        s2_d       = s1_q;
        pclk_s3_d  = pclk_s2;
        vsync_s3_d = vsync_s2;
        href_s3_d  = href_s2;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        done_d   = 1'b0;
        fstart_d = 1'b0;
        fdone_d  = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // Bus traffic is ignored until a clean frame boundary
                if (vs_fall) begin
                    state_d  = ACTIVE;
                    fstart_d = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    phase_d  = 1'b0;
                end
            end
            ACTIVE: begin
                // Frame end has priority over any coincident byte or line end
                if (vs_rise) begin
                    state_d = IDLE;
                    fdone_d = 1'b1;
                    phase_d = 1'b0;
                    if (row_q != ROW_MAX) begin
                        err_d = 1'b1;
                    end
                end else if (href_fall) begin
                    if ((col_q != COL_MAX) || phase_q) begin
                        err_d = 1'b1;
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                    if (row_q != ROW_MAX) begin
                        row_d = row_q + ROW_ONE;
                    end
                end else if (pe && href_s2) begin
                    if (!phase_q) begin
                        hi_d    = data_s2;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((col_q < COL_MAX) && (row_q < ROW_MAX)) begin
                            // RGB565 -> RGB888 by MSB replication
                            red_d   = {hi_q[7:3], hi_q[7:5]};
                            green_d = {hi_q[2:0], data_s2[7:5], hi_q[2:1]};
                            blue_d  = {data_s2[4:0], data_s2[4:2]};
                            done_d  = 1'b1;
                            col_d   = col_q + COL_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            pclk_s3_q  <= 1'b0;
            vsync_s3_q <= 1'b0;
            href_s3_q  <= 1'b0;
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            done_q     <= 1'b0;
            fstart_q   <= 1'b0;
            fdone_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            pclk_s3_q  <= pclk_s3_d;
            vsync_s3_q <= vsync_s3_d;
            href_s3_q  <= href_s3_d;
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            done_q     <= done_d;
            fstart_q   <= fstart_d;
            fdone_q    <= fdone_d;
            err_q      <= err_d;
        end
    end

    assign cam_red_o     = red_q;
    assign cam_green_o   = green_q;
    assign cam_blue_o    = blue_q;
    assign cam_done_o    = done_q;
    assign frame_start_o = fstart_q;
    assign frame_done_o  = fdone_q;
    assign cap_err_o     = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_capture
//
// Directed bench for cam_capture with a 4x2 frame and clk:pclk = 4:1.
// Stimulus pushes hand-computed RGB888 values into a queue; a monitor pops
// and compares on every cam_done_o strobe and counts frame pulses.
// ---------------------------------------------------------------------------
module tb_cam_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       cam_pclk_i;
    logic       cam_vsync_i;
    logic       cam_href_i;
    logic [7:0] cam_data_i;
    logic [7:0] cam_red_o;
    logic [7:0] cam_green_o;
    logic [7:0] cam_blue_o;
    logic       cam_done_o;
    logic       frame_start_o;
    logic       frame_done_o;
    logic       cap_err_o;

    cam_capture #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cam_pclk_i   (cam_pclk_i),
        .cam_vsync_i  (cam_vsync_i),
        .cam_href_i   (cam_href_i),
        .cam_data_i   (cam_data_i),
        .cam_red_o    (cam_red_o),
        .cam_green_o  (cam_green_o),
        .cam_blue_o   (cam_blue_o),
        .cam_done_o   (cam_done_o),
        .frame_start_o(frame_start_o),
        .frame_done_o (frame_done_o),
        .cap_err_o    (cap_err_o)
    );

    always #5 clk = ~clk;

    // Hand-computed test pixels: bytes and their RGB888 expansions
    localparam logic [7:0]  BASIC_HI[4]  = '{8'hF8, 8'h07, 8'h00, 8'hFF};
    localparam logic [7:0]  BASIC_LO[4]  = '{8'h00, 8'hE0, 8'h1F, 8'hFF};
    localparam logic [23:0] BASIC_EXP[4] = '{24'hFF0000, 24'h00FF00,
                                             24'h0000FF, 24'hFFFFFF};

    logic [23:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;
    int fs_cnt   = 0;
    int fd_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one line per pixel strobe, compared against the scoreboard
    always @(negedge clk) begin
        if (cam_done_o) begin
            strobes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe actual=%06h required=no_strobe",
                         {cam_red_o, cam_green_o, cam_blue_o});
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                $display("pixel rgb=%06h expected=%06h",
                         {cam_red_o, cam_green_o, cam_blue_o}, e);
                check("pixel_rgb", {8'h00, cam_red_o, cam_green_o, cam_blue_o},
                      {8'h00, e});
            end
        end
        if (frame_start_o) fs_cnt++;
        if (frame_done_o) fd_cnt++;
    end

    // All bus tasks start and end on a falling clk edge
    task automatic send_byte(input logic [7:0] b);
        cam_pclk_i = 1'b0;
        cam_data_i = b;
        cam_href_i = 1'b1;
        repeat (2) @(negedge clk);
        cam_pclk_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic px(input logic [7:0] hi, input logic [7:0] lo,
                      input logic [23:0] e, input bit expect_it);
        send_byte(hi);
        if (expect_it) exp_q.push_back(e);
        send_byte(lo);
    endtask

    task automatic line_end();
        cam_pclk_i = 1'b0;
        cam_href_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic full_line(input bit expect_it);
        for (int i = 0; i < 4; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], expect_it);
        line_end();
    endtask

    task automatic vs_set(input logic v);
        cam_vsync_i = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rgb"}, {8'h00, cam_red_o, cam_green_o, cam_blue_o}, 32'h0);
        check({tag, "_done"}, cam_done_o, 1'b0);
        check({tag, "_fstart"}, frame_start_o, 1'b0);
        check({tag, "_fdone"}, frame_done_o, 1'b0);
        check({tag, "_err"}, cap_err_o, 1'b0);
    endtask

    initial begin
        int s0;
        int fd0;
        int fs0;
        rst         = 1'b1;
        cam_pclk_i  = 1'b0;
        cam_vsync_i = 1'b1;
        cam_href_i  = 1'b0;
        cam_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Line traffic before any vsync fall must be ignored
        full_line(1'b0);
        check("idle_strobes", strobes, 0);
        check("idle_fstart", fs_cnt, 0);

        // Basic 4x2 frame
        vs_set(1'b0);
        check("frame_start", fs_cnt, 1);
        full_line(1'b1);
        full_line(1'b1);
        vs_set(1'b1);
        check("frame_done", fd_cnt, 1);
        check("basic_strobes", strobes, 8);
        check("basic_err", cap_err_o, 1'b0);
        check("basic_drained", exp_q.size(), 0);

        // Expansion vector 0x84,0x10 -> 84,82,84
        vs_set(1'b0);
        px(8'h84, 8'h10, 24'h848284, 1'b1);
        for (int i = 1; i < 4; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], 1'b1);
        line_end();
        full_line(1'b1);
        vs_set(1'b1);
        check("expand_err", cap_err_o, 1'b0);
        check("expand_drained", exp_q.size(), 0);

        // Vsync rise coincident with the second byte's pclk edge
        vs_set(1'b0);
        s0  = strobes;
        fd0 = fd_cnt;
        full_line(1'b1);
        for (int i = 0; i < 3; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], 1'b1);
        send_byte(BASIC_HI[3]);
        cam_pclk_i = 1'b0;
        cam_data_i = BASIC_LO[3];
        repeat (2) @(negedge clk);
        cam_pclk_i  = 1'b1;
        cam_vsync_i = 1'b1;
        repeat (8) @(negedge clk);
        line_end();
        check("coincident_strobes", strobes - s0, 7);
        check("coincident_fdone", fd_cnt, fd0 + 1);
        check("coincident_err_short_frame", cap_err_o, 1'b1);
        check("coincident_drained", exp_q.size(), 0);
        pulse_rst();
        check("rst_clears_err", cap_err_o, 1'b0);

        // Short line: 3 pixels, error sticks until reset
        vs_set(1'b0);
        for (int i = 0; i < 3; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], 1'b1);
        line_end();
        check("short_line_err", cap_err_o, 1'b1);
        full_line(1'b1);
        vs_set(1'b1);
        check("short_line_sticky", cap_err_o, 1'b1);
        check("short_drained", exp_q.size(), 0);
        pulse_rst();

        // Odd byte count: 9 bytes -> 4 strobes, trailing byte dropped
        vs_set(1'b0);
        s0 = strobes;
        for (int i = 0; i < 4; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], 1'b1);
        send_byte(8'hAA);
        line_end();
        check("odd_strobes", strobes - s0, 4);
        check("odd_err", cap_err_o, 1'b1);
        vs_set(1'b1);
        pulse_rst();
        check("odd_rst_err", cap_err_o, 1'b0);

        // Long line: 5 pixels -> 4 strobes, RGB holds the 4th pixel
        vs_set(1'b0);
        s0 = strobes;
        for (int i = 0; i < 4; i++) px(BASIC_HI[i], BASIC_LO[i], BASIC_EXP[i], 1'b1);
        px(BASIC_HI[0], BASIC_LO[0], BASIC_EXP[0], 1'b0);
        line_end();
        check("long_strobes", strobes - s0, 4);
        check("long_err", cap_err_o, 1'b1);
        check("long_rgb_held", {8'h00, cam_red_o, cam_green_o, cam_blue_o}, 32'h00FFFFFF);
        vs_set(1'b1);
        pulse_rst();

        // Reset in the middle of a line, then a clean frame
        vs_set(1'b0);
        px(BASIC_HI[0], BASIC_LO[0], BASIC_EXP[0], 1'b1);
        px(BASIC_HI[1], BASIC_LO[1], BASIC_EXP[1], 1'b1);
        send_byte(BASIC_HI[2]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        s0  = strobes;
        fd0 = fd_cnt;
        send_byte(BASIC_LO[2]);
        px(BASIC_HI[3], BASIC_LO[3], BASIC_EXP[3], 1'b0);
        line_end();
        full_line(1'b0);
        check("midrst_no_strobes", strobes - s0, 0);
        check("midrst_rgb_zero", {8'h00, cam_red_o, cam_green_o, cam_blue_o}, 32'h0);
        vs_set(1'b1);
        check("midrst_no_fdone_idle", fd_cnt, fd0);
        fs0 = fs_cnt;
        vs_set(1'b0);
        check("midrst_fstart", fs_cnt, fs0 + 1);
        s0 = strobes;
        full_line(1'b1);
        full_line(1'b1);
        vs_set(1'b1);
        check("midrst_frame_strobes", strobes - s0, 8);
        check("midrst_frame_err", cap_err_o, 1'b0);
        check("midrst_fdone", fd_cnt, fd0 + 1);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
